// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stage-register load/flush control for a five-stage pipeline.
//               It freezes every stage while an instruction fetch or a data
//               access is still outstanding. Responses that arrive during a
//               freeze are remembered so the memory is not asked again. When
//               the pipeline is free to move, a taken branch flushes the two
//               youngest stages. A load-use hazard holds PC and IF/ID and
//               puts a bubble into ID/EX. A saturating counter records the
//               number of cycles lost to memory stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_access,
  input  logic        dmem_resp,
  input  logic        load_use,
  input  logic        br_taken,
  output logic        load_pc,
  output logic        load_if_id,
  output logic        load_id_ex,
  output logic        load_ex_mem,
  output logic        load_mem_wb,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        imem_hold,
  output logic        dmem_hold,
  output logic [31:0] stall_count,
  output logic        state
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] C_STALL_MAX = 32'hFFFF_FFFF;

  state_t      r_state;
  logic        r_i_done;
  logic        r_d_done;
  logic [31:0] r_stall_count;

  logic        w_i_ok;
  logic        w_d_ok;
  logic        w_ready;

  // Each side is satisfied if it asks for nothing, or if it is answered now,
  // or if it was answered during an earlier frozen cycle.
  assign w_i_ok  = !imem_read   | imem_resp | r_i_done;
  assign w_d_ok  = !dmem_access | dmem_resp | r_d_done;
  assign w_ready = w_i_ok & w_d_ok;

  // State register, remembered responses and stall counter. Reset takes
  // priority over everything, so an interrupted wait leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_i_done      <= 1'b0;
      r_d_done      <= 1'b0;
      r_stall_count <= '0;
    end else if (!w_ready) begin
      r_state  <= ST_MEM_WAIT;
      r_i_done <= r_i_done | (imem_read & imem_resp);
      r_d_done <= r_d_done | (dmem_access & dmem_resp);
      if (r_stall_count != C_STALL_MAX) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end else begin
      r_state  <= ST_RUN;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
    end
  end

  // Load and flush enables. These are combinational on ready, so the stages
  // move in the same cycle that the last response arrives. Hazard inputs are
  // looked at only on a ready cycle. A flush is raised only together with
  // the load of the same stage.
  always_comb begin
    load_pc     = 1'b0;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    if (!rst && w_ready) begin
      load_id_ex  = 1'b1;
      load_ex_mem = 1'b1;
      load_mem_wb = 1'b1;
      if (br_taken) begin
        load_pc     = 1'b1;
        load_if_id  = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (load_use) begin
        flush_id_ex = 1'b1;
      end else begin
        load_pc    = 1'b1;
        load_if_id = 1'b1;
      end
    end
  end

  // A remembered response tells the memory side not to issue the request
  // again. This indication is masked while reset is asserted.
  assign imem_hold   = !rst & r_i_done;
  assign dmem_hold   = !rst & r_d_done;

  assign stall_count = r_stall_count;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have inputs: imem_read 1 (IF issuing fetch); imem_resp 1 (fetch done); dmem_access 1 (EX/MEM holds load/store); dmem_resp 1 (data access done); load_use 1 (ID depends on load in EX); br_taken 1 (EX redirect).
REQ-003 SHALL have outputs: load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, each 1 bit; stage-register load enables.
REQ-004 SHALL have outputs: flush_if_id, flush_id_ex, each 1 bit; replace the stage's next contents with a bubble (all-zero).
REQ-005 SHALL have outputs: imem_hold, dmem_hold, each 1 bit; memory already served, suppress re-request.
REQ-006 SHALL have output: stall_count 32 bits; memory-stall cycle counter.
REQ-007 SHALL have output: state 1 bit; 0=RUN, 1=MEM_WAIT.

Function
REQ-008 SHALL hold internal flags i_done and d_done, each set on a response that arrives while the pipeline cannot advance.
REQ-009 SHALL compute ready = (!imem_read | imem_resp | i_done) & (!dmem_access | dmem_resp | d_done), combinationally.
REQ-010 SHALL implement FSM: RUN -> MEM_WAIT when !ready; MEM_WAIT -> RUN when ready; otherwise hold state.
REQ-011 While !ready, SHALL drive all five load_* and both flush_* to 0.
REQ-012 While !ready, SHALL set i_done on imem_resp&imem_read and d_done on dmem_resp&dmem_access, effective next cycle.
REQ-013 On a ready cycle, SHALL clear i_done and d_done next cycle.
REQ-014 SHALL drive imem_hold = i_done and dmem_hold = d_done.
REQ-015 On ready with br_taken=1, SHALL assert all five loads and both flushes; br_taken has priority over load_use.
REQ-016 On ready with br_taken=0 and load_use=1, SHALL drive load_pc=0, load_if_id=0, load_id_ex=1, flush_id_ex=1, load_ex_mem=1, load_mem_wb=1, flush_if_id=0.
REQ-017 On ready with br_taken=0 and load_use=0, SHALL assert all loads and deassert both flushes.
REQ-018 SHALL ignore br_taken and load_use while !ready; these inputs take effect on the first ready cycle.
REQ-019 SHALL keep flush_* asserted only when the matching load_* is asserted.
REQ-020 SHALL increment stall_count each cycle !ready, saturating at 32'hFFFF_FFFF with no wrap.
REQ-021 SHALL complete the advance in the same cycle when both responses arrive together or the final response arrives, with zero added latency.

Reset
REQ-022 While rst=1, SHALL force all load_* to 0, all flush_* to 0, and imem_hold and dmem_hold to 0.
REQ-023 On rst, SHALL set i_done=0, d_done=0, state=RUN, and stall_count=0 on the next edge.
REQ-024 An rst asserted in MEM_WAIT SHALL abort the wait and discard latched flags; the first post-reset cycle is evaluated from inputs only.

Verification
REQ-025 Idle case: imem_read=1, imem_resp=1, all else 0 -> all loads 1, flushes 0, state RUN, stall_count stays 0.
REQ-026 Split responses: imem_read=1, dmem_access=1; imem_resp at cycle 1, dmem_resp at cycle 4 -> loads 0 in cycles 0-3, imem_hold=1 in cycles 2-4, all loads 1 in cycle 4, stall_count=4.
REQ-027 Load-use: ready, load_use=1 -> load_pc=0, load_if_id=0, load_id_ex=1, flush_id_ex=1, flush_if_id=0.
REQ-028 Branch during stall: br_taken=1 and load_use=1 held through a 3-cycle dmem wait -> no flush during the wait; on the ready cycle all loads 1 and both flushes 1.
REQ-029 Reset in MEM_WAIT: with d_done=1, assert rst for 1 cycle -> loads 0 during rst; afterwards dmem_hold=0, state RUN, stall_count=0.
REQ-030 Saturation: preload stall_count near max via long stall (or force) -> holds 32'hFFFF_FFFF, with no wrap.
